mdp3_stream_ctrl: RTL and testbench

Flow and read controller for the MDP3 streaming datapath: packetizer, 64x256 single-clock FIFO, parser. It drives Avalon-ST `ready` toward the upstream source with watermark hysteresis and sequences FIFO reads into the parser so words are presented one per cycle. It also gates reads on order-book enable and handles flush. It keeps sticky framing and overflow error flags plus wrap-around statistics counters for the debug path.

---
 rtl/mdp3_stream_ctrl_if.sv | 38 +++
 rtl/mdp3_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_mdp3_stream_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdp3_stream_ctrl_if.sv
// Bundle of the upstream Avalon-ST qualifiers, FIFO handshake, parser handshake and debug outputs.
// The controller uses the slave modport; the surrounding datapath (or a bench) uses master.
interface mdp3_stream_ctrl_if #(
  parameter int USEDW_W = 8
);
  logic               st_valid;
  logic               st_sop;
  logic               st_eop;
  logic               st_ready;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_wrreq;
  logic               fifo_rdreq;
  logic               fifo_sclr;
  logic               flush;
  logic               ob_enable;
  logic               word_valid;
  logic               word_take;
  logic               overflow_err;
  logic               frame_err;
  logic [31:0]        pkt_count;
  logic [31:0]        words_out;

  modport master (
    output st_valid, st_sop, st_eop, fifo_usedw, fifo_empty, fifo_full, fifo_wrreq,
           flush, ob_enable, word_take,
    input  st_ready, fifo_rdreq, fifo_sclr, word_valid, overflow_err, frame_err,
           pkt_count, words_out
  );

  modport slave (
    input  st_valid, st_sop, st_eop, fifo_usedw, fifo_empty, fifo_full, fifo_wrreq,
           flush, ob_enable, word_take,
    output st_ready, fifo_rdreq, fifo_sclr, word_valid, overflow_err, frame_err,
           pkt_count, words_out
  );
endinterface

// File: rtl/mdp3_stream_ctrl.sv
// MDP3 stream controller: st_ready watermark hysteresis, FIFO read sequencing into the parser,
// flush handling, sticky framing/overflow flags and wrapping statistics counters.
module mdp3_stream_ctrl #(
  parameter int USEDW_W = 8,
  parameter int AF_HI   = 240,
  parameter int AF_LO   = 192
) (
  input  logic              clk,
  input  logic              reset,
  mdp3_stream_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [USEDW_W-1:0] AF_HI_LVL = USEDW_W'(AF_HI);
  localparam logic [USEDW_W-1:0] AF_LO_LVL = USEDW_W'(AF_LO);

  logic [1:0]  state_q, state_d;
  logic        hold_q, hold_d;
  logic        in_pkt_q, in_pkt_d;
  logic        st_ready_q, st_ready_d;
  logic        word_valid_q, word_valid_d;
  logic        sclr_q, sclr_d;
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] words_out_q, words_out_d;
  logic        can_read;
  logic        rdreq;
  logic        accepted;

  always_comb begin
    can_read = !bus.fifo_empty && bus.ob_enable && !bus.flush;
    state_d  = state_q;
    rdreq    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_read) begin
          rdreq   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        // A held word keeps q stable: no read until the parser takes it.
        if (bus.word_take) begin
          if (can_read) rdreq = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_CLEAR;
      rdreq   = 1'b0;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (bus.fifo_full || (bus.fifo_usedw >= AF_HI_LVL))
      hold_d = 1'b1;
    else if (bus.fifo_usedw <= AF_LO_LVL)
      hold_d = 1'b0;

    st_ready_d   = !hold_d && (state_d != S_CLEAR);
    word_valid_d = (state_d == S_DATA);
    sclr_d       = (state_d == S_CLEAR);

    words_out_d = words_out_q;
    if ((state_q == S_DATA) && bus.word_take)
      words_out_d = words_out_q + 32'd1;

    overflow_d = overflow_q || (bus.fifo_wrreq && bus.fifo_full);

    // SOP+EOP in one beat is a complete packet and leaves in_pkt clear.
    accepted    = bus.st_valid && st_ready_q;
    in_pkt_d    = in_pkt_q;
    frame_err_d = frame_err_q;
    pkt_count_d = pkt_count_q;
    if (accepted) begin
      if ((bus.st_sop && in_pkt_q) || (bus.st_eop && !bus.st_sop && !in_pkt_q))
        frame_err_d = 1'b1;
      if (bus.st_eop) begin
        in_pkt_d    = 1'b0;
        pkt_count_d = pkt_count_q + 32'd1;
      end else if (bus.st_sop) begin
        in_pkt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= 1'b0;
      in_pkt_q     <= 1'b0;
      st_ready_q   <= 1'b0;
      word_valid_q <= 1'b0;
      sclr_q       <= 1'b1;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      pkt_count_q  <= 32'd0;
      words_out_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      in_pkt_q     <= in_pkt_d;
      st_ready_q   <= st_ready_d;
      word_valid_q <= word_valid_d;
      sclr_q       <= sclr_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      pkt_count_q  <= pkt_count_d;
      words_out_q  <= words_out_d;
    end
  end

  assign bus.fifo_rdreq   = rdreq && !reset;
  assign bus.st_ready     = st_ready_q;
  assign bus.word_valid   = word_valid_q;
  assign bus.fifo_sclr    = sclr_q;
  assign bus.overflow_err = overflow_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.pkt_count    = pkt_count_q;
  assign bus.words_out    = words_out_q;

endmodule

// File: tb/tb_mdp3_stream_ctrl.sv
// Directed bench for mdp3_stream_ctrl; a small occupancy model stands in for the FIFO empty flag.
module tb_mdp3_stream_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;
  int   cnt = 0;

  mdp3_stream_ctrl_if #(.USEDW_W(8)) bus ();

  mdp3_stream_ctrl #(.USEDW_W(8), .AF_HI(240), .AF_LO(192)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fifo_sclr) cnt <= 0;
    else cnt <= cnt + ((bus.fifo_wrreq && !bus.fifo_full) ? 1 : 0) - (bus.fifo_rdreq ? 1 : 0);
  end
  assign bus.fifo_empty = (cnt == 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic s, input logic e, input logic w);
    bus.st_valid = v; bus.st_sop = s; bus.st_eop = e; bus.fifo_wrreq = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL rst_st_ready got %0b exp 0", bus.st_ready); end
    checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL rst_word_valid got %0b exp 0", bus.word_valid); end
    checks++; if (bus.fifo_sclr !== 1'b1) begin fails++; $display("FAIL rst_sclr got %0b exp 1", bus.fifo_sclr); end
    checks++; if (bus.fifo_rdreq !== 1'b0) begin fails++; $display("FAIL rst_rdreq got %0b exp 0", bus.fifo_rdreq); end
    checks++; if (bus.pkt_count !== 32'd0 || bus.words_out !== 32'd0) begin fails++; $display("FAIL rst_counters got %0d/%0d exp 0/0", bus.pkt_count, bus.words_out); end
    checks++; if (bus.frame_err !== 1'b0 || bus.overflow_err !== 1'b0) begin fails++; $display("FAIL rst_flags got %0b/%0b exp 0/0", bus.frame_err, bus.overflow_err); end
    reset = 1'b0;
    tick();
    checks++; if (bus.fifo_sclr !== 1'b0) begin fails++; $display("FAIL post_rst_sclr got %0b exp 0", bus.fifo_sclr); end
    checks++; if (bus.st_ready !== 1'b1) begin fails++; $display("FAIL post_rst_st_ready got %0b exp 1", bus.st_ready); end
  endtask

  task automatic test_streaming();
    int nwv = 0;
    bus.word_take = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (bus.fifo_rdreq !== 1'b1) begin fails++; $display("FAIL stream_first_rdreq got %0b exp 1", bus.fifo_rdreq); end
    for (int i = 1; i < 12; i++) begin
      beat(i < 3, 1'b0, i == 2, i < 3);
      #1;
      if (bus.word_valid === 1'b1) nwv++;
      tick();
    end
    checks++; if (nwv !== 3) begin fails++; $display("FAIL stream_wv_cycles got %0d exp 3", nwv); end
    checks++; if (bus.words_out !== 32'd3) begin fails++; $display("FAIL stream_words_out got %0d exp 3", bus.words_out); end
    checks++; if (bus.pkt_count !== 32'd1) begin fails++; $display("FAIL stream_pkt_count got %0d exp 1", bus.pkt_count); end
  endtask

  task automatic test_parser_stall();
    bus.word_take = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b1); tick(); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && bus.word_valid !== 1'b1; i++) tick();
    checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL stall_wait_wv got %0b exp 1", bus.word_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.word_valid !== 1'b1 || bus.fifo_rdreq !== 1'b0) begin fails++; $display("FAIL stall_hold wv/rdreq got %0b/%0b exp 1/0", bus.word_valid, bus.fifo_rdreq); end
      tick();
    end
    bus.word_take = 1'b1;
    #1;
    checks++; if (bus.fifo_rdreq !== 1'b1) begin fails++; $display("FAIL stall_release_rdreq got %0b exp 1", bus.fifo_rdreq); end
    tick();
    checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL stall_second_wv got %0b exp 1", bus.word_valid); end
    tick();
    checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL stall_drained_wv got %0b exp 0", bus.word_valid); end
    checks++; if (bus.words_out !== 32'd5) begin fails++; $display("FAIL stall_words_out got %0d exp 5", bus.words_out); end
  endtask

  task automatic test_ob_halt();
    bus.word_take = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && bus.word_valid !== 1'b1; i++) tick();
    checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL ob_wait_wv got %0b exp 1", bus.word_valid); end
    bus.ob_enable = 1'b0; bus.word_take = 1'b1;
    #1;
    checks++; if (bus.fifo_rdreq !== 1'b0) begin fails++; $display("FAIL ob_halt_rdreq got %0b exp 0", bus.fifo_rdreq); end
    tick();
    checks++; if (bus.words_out !== 32'd6 || bus.word_valid !== 1'b0) begin fails++; $display("FAIL ob_taken words/wv got %0d/%0b exp 6/0", bus.words_out, bus.word_valid); end
    tick();
    checks++; if (bus.fifo_rdreq !== 1'b0) begin fails++; $display("FAIL ob_idle_rdreq got %0b exp 0", bus.fifo_rdreq); end
    bus.ob_enable = 1'b1;
    #1;
    checks++; if (bus.fifo_rdreq !== 1'b1) begin fails++; $display("FAIL ob_resume_rdreq got %0b exp 1", bus.fifo_rdreq); end
    for (int i = 0; i < 8; i++) tick();
    checks++; if (bus.words_out !== 32'd8) begin fails++; $display("FAIL ob_drain_words got %0d exp 8", bus.words_out); end
    bus.word_take = 1'b0;
  endtask

  task automatic test_watermark();
    bus.fifo_usedw = 8'd239; tick();
    checks++; if (bus.st_ready !== 1'b1) begin fails++; $display("FAIL wm_239 got %0b exp 1", bus.st_ready); end
    bus.fifo_usedw = 8'd240; tick();
    checks++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL wm_240 got %0b exp 0", bus.st_ready); end
    bus.fifo_usedw = 8'd200; tick();
    checks++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL wm_200 got %0b exp 0", bus.st_ready); end
    bus.fifo_usedw = 8'd192; tick();
    checks++; if (bus.st_ready !== 1'b1) begin fails++; $display("FAIL wm_192 got %0b exp 1", bus.st_ready); end
    bus.fifo_usedw = 8'd100; bus.fifo_full = 1'b1; tick();
    checks++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL wm_full got %0b exp 0", bus.st_ready); end
    bus.fifo_full = 1'b0; tick();
    checks++; if (bus.st_ready !== 1'b1) begin fails++; $display("FAIL wm_unfull got %0b exp 1", bus.st_ready); end
  endtask

  task automatic test_errors();
    beat(1'b1, 1'b1, 1'b0, 1'b0); tick();
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL err_first_sop got %0b exp 0", bus.frame_err); end
    tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0); tick();
    checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL err_sop_sop got %0b exp 1", bus.frame_err); end
    checks++; if (bus.overflow_err !== 1'b0) begin fails++; $display("FAIL err_ovf_pre got %0b exp 0", bus.overflow_err); end
    bus.fifo_full = 1'b1; bus.fifo_wrreq = 1'b1; tick();
    bus.fifo_full = 1'b0; bus.fifo_wrreq = 1'b0;
    checks++; if (bus.overflow_err !== 1'b1) begin fails++; $display("FAIL err_ovf got %0b exp 1", bus.overflow_err); end
    tick(); tick(); tick();
    checks++; if (bus.frame_err !== 1'b1 || bus.overflow_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %0b/%0b exp 1/1", bus.frame_err, bus.overflow_err); end
  endtask

  task automatic test_flush();
    logic [31:0] pkts;
    bus.word_take = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b1); tick(); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && bus.word_valid !== 1'b1; i++) tick();
    checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL flush_wait_wv got %0b exp 1", bus.word_valid); end
    pkts = bus.pkt_count;
    bus.flush = 1'b1; bus.word_take = 1'b1;
    #1;
    checks++; if (bus.fifo_rdreq !== 1'b0) begin fails++; $display("FAIL flush_rdreq got %0b exp 0", bus.fifo_rdreq); end
    tick();
    bus.flush = 1'b0; bus.word_take = 1'b0;
    checks++; if (bus.fifo_sclr !== 1'b1 || bus.word_valid !== 1'b0 || bus.st_ready !== 1'b0) begin fails++; $display("FAIL flush_clear sclr/wv/rdy got %0b/%0b/%0b exp 1/0/0", bus.fifo_sclr, bus.word_valid, bus.st_ready); end
    checks++; if (bus.words_out !== 32'd9) begin fails++; $display("FAIL flush_words got %0d exp 9", bus.words_out); end
    tick();
    checks++; if (bus.fifo_sclr !== 1'b0 || bus.st_ready !== 1'b1 || bus.word_valid !== 1'b0) begin fails++; $display("FAIL flush_idle sclr/rdy/wv got %0b/%0b/%0b exp 0/1/0", bus.fifo_sclr, bus.st_ready, bus.word_valid); end
    checks++; if (bus.pkt_count !== pkts) begin fails++; $display("FAIL flush_pkts got %0d exp %0d", bus.pkt_count, pkts); end
  endtask

  task automatic test_reset_mid_packet();
    beat(1'b1, 1'b1, 1'b0, 1'b0); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; tick();
    checks++; if (bus.fifo_sclr !== 1'b1 || bus.frame_err !== 1'b0 || bus.overflow_err !== 1'b0) begin fails++; $display("FAIL midrst sclr/ferr/ovf got %0b/%0b/%0b exp 1/0/0", bus.fifo_sclr, bus.frame_err, bus.overflow_err); end
    checks++; if (bus.words_out !== 32'd0 || bus.pkt_count !== 32'd0) begin fails++; $display("FAIL midrst_counters got %0d/%0d exp 0/0", bus.words_out, bus.pkt_count); end
    reset = 1'b0; tick();
    beat(1'b1, 1'b1, 1'b0, 1'b0); tick();
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL midrst_sop got %0b exp 0", bus.frame_err); end
    beat(1'b1, 1'b0, 1'b1, 1'b0); tick();
    beat(1'b1, 1'b1, 1'b1, 1'b0); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.pkt_count !== 32'd2 || bus.frame_err !== 1'b0) begin fails++; $display("FAIL sop_eop_beat pkts/ferr got %0d/%0b exp 2/0", bus.pkt_count, bus.frame_err); end
    beat(1'b1, 1'b0, 1'b1, 1'b0); tick();
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL eop_outside_pkt got %0b exp 1", bus.frame_err); end
  endtask

  initial begin
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    bus.fifo_usedw = 8'd0; bus.fifo_full = 1'b0; bus.flush = 1'b0;
    bus.ob_enable = 1'b1; bus.word_take = 1'b0;
    test_reset();
    test_streaming();
    test_parser_stall();
    test_ob_halt();
    test_watermark();
    test_errors();
    test_flush();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
